vdc_ram_sched: RTL
==================

Name: vdc_ram_sched

Overview:
- Per-slot VRAM access scheduler for the VDC.
- Each enable slot grants exactly one RAM cycle to one of: DRAM refresh, screen fetch, attribute fetch, character/bitmap fetch, or CPU access.
- Fills the row/char latches consumed by the video pixel stage and owns the rowbuf toggle.
- Sits between the VDC register file, the sync/timing generator and the single-port VRAM.

Parameters:
S_LATCH_WIDTH, 80, screen/attribute latch depth per row buffer
C_LATCH_WIDTH, 80, character latch depth

Ports:
clk  in  1  core clock
reset  in  1  asynchronous reset, active-low
enable  in  1  RAM slot strobe; one access issued per strobe
fetchFrame  in  1  frame-start pulse
fetchLine  in  1  visible-line-start pulse
fetchRow  in  1  visible-row-start pulse (coincides with fetchLine)
reg_hd  in  8  columns to fetch
reg_drr  in  4  refresh cycles per line
reg_text  in  1  1=bitmap mode
reg_atr  in  1  attribute enable
reg_ram64  in  1  0=16K address mask, 1=64K
reg_cbase  in  3  charset base, address bits 15:13
reg_csz  in  1  0=16, 1=32 bytes per glyph
line  in  5  current line within row
dispaddr  in  16  screen/bitmap address of current row/line
attraddr  in  16  attribute address of next row
scrn_code  in  8  screen code at index char_idx of buffer rowbuf (combinational)
char_idx  out  8  lookup index for scrn_code
cpu_req  in  1  CPU access request (level)
cpu_we  in  1  CPU write
cpu_addr  in  16  CPU address
cpu_wdata  in  8  CPU write data
cpu_ack  out  1  one-cycle completion pulse
cpu_rdata  out  8  read data, valid with cpu_ack
ram_addr  out  16  VRAM address
ram_we  out  1  VRAM write strobe
ram_wdata  out  8  VRAM write data
ram_rdata  in  8  VRAM data of previous slot
buf_we  out  1  latch write strobe
buf_sel  out  2  0=screen, 1=attr, 2=char
buf_row  out  1  target row buffer for screen/attr writes
buf_idx  out  8  latch index
buf_data  out  8  latch data
rowbuf  out  1  buffer holding the current row
overrun  out  1  sticky; fetch aborted by new fetchLine

Behaviour:
- Reset: all outputs 0; state IDLE; refresh counter 0; no pending read.
- States: IDLE, REFR, SCRN, ATTR, CHAR. Transitions are evaluated only on enable, except fetch pulses, which are latched on any clk.
- fetchLine latches line_pend. fetchRow latches row_pend and toggles rowbuf. fetchFrame forces rowbuf=0 and takes priority over the fetchRow toggle.
- On an enable with line_pend set:
  - If state is not IDLE, set overrun=1 (sticky until reset).
  - Clear line_pend, go to REFR, index i=0.
- REFR:
  - reg_drr slots; ram_addr={8'h00,refcnt}, refcnt+=1 mod 256.
  - reg_drr=0 skips REFR.
  - Exit to SCRN if row_pend && !reg_text; else ATTR if row_pend && reg_atr; else CHAR.
- SCRN: fetch dispaddr+i for i=0..N-1, N=min(reg_hd,S_LATCH_WIDTH). Then go to ATTR if reg_atr, else CHAR.
- ATTR: fetch attraddr+i, same N. Clear row_pend on exit. Go to CHAR.
- CHAR: M=min(reg_hd,C_LATCH_WIDTH); char_idx=i.
  - Text mode: address={reg_cbase,13'b0} + (reg_csz ? {scrn_code,line} : {scrn_code,line[3:0]}).
  - Bitmap mode: address=dispaddr+i.
  - After M slots go to IDLE.
- N=0 or M=0 skips the phase in zero slots.
- Address width:
  - All address sums are mod 2^16.
  - Final ram_addr is ANDed with 16'h3FFF when reg_ram64=0.
- IDLE: if cpu_req, issue cpu_addr/cpu_we/cpu_wdata. No CPU access is granted in any other state.
- Read pipeline:
  - Data for a read issued in slot k is sampled from ram_rdata on slot k+1's enable.
  - Fetch reads then produce a one-clk buf_we with buf_sel/buf_idx=i of slot k, and buf_row=~rowbuf for screen/attr.
  - CPU reads produce cpu_ack with cpu_rdata.
  - CPU writes ack on the issuing enable.
- ram_we is high only during the issuing clk of a CPU write.
- The pending read tag survives state changes. An abort never drops an in-flight latch write.
- Simultaneous events: fetchLine and cpu_req in the same slot give line precedence; the CPU waits until the next IDLE.
- Asynchronous reset mid-fetch: return to IDLE immediately; no buf_we or cpu_ack follows.

Test Plan:
- Reset, then reg_drr=5, fetchLine, idle otherwise → 5 REFR slots with ram_addr 0x0000..0x0004, then IDLE; refcnt wraps 0xFF→0x00 on the 256th slot.
- reg_hd=80, reg_atr=1, reg_text=0, dispaddr=0x0000, attraddr=0x0800, fetchRow+fetchLine → rowbuf toggles; 80 screen writes (buf_sel=0, buf_row=~rowbuf), 80 attr writes; cursor at 0x0800+79.
- Text CHAR with reg_cbase=1, scrn_code=0x41, line=3, reg_csz=0 → ram_addr=0x2413; reg_csz=1, line=17 → 0x2831.
- reg_ram64=0, dispaddr=0xFFFE, reg_hd=4 → addresses 0x3FFE, 0x3FFF, 0x0000, 0x0001.
- cpu_req read at 0x1234 while in SCRN → no grant until IDLE; then cpu_ack exactly one enable after issue, with cpu_rdata = ram_rdata.
- fetchLine arriving mid-CHAR → overrun=1; the final in-flight buf_we still occurs; sequence restarts at REFR.

Source files
------------

// File: rtl/vdc_ram_sched.sv
// VRAM slot scheduler: arbitrates refresh, screen/attribute/character fetches and CPU
// access, one RAM cycle per enable strobe, and writes fetched bytes into the row latches.
module vdc_ram_sched #(
  parameter int unsigned S_LATCH_WIDTH = 80,
  parameter int unsigned C_LATCH_WIDTH = 80
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        fetchFrame,
  input  logic        fetchLine,
  input  logic        fetchRow,
  input  logic [7:0]  reg_hd,
  input  logic [3:0]  reg_drr,
  input  logic        reg_text,
  input  logic        reg_atr,
  input  logic        reg_ram64,
  input  logic [2:0]  reg_cbase,
  input  logic        reg_csz,
  input  logic [4:0]  line,
  input  logic [15:0] dispaddr,
  input  logic [15:0] attraddr,
  input  logic [7:0]  scrn_code,
  output logic [7:0]  char_idx,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic        cpu_ack,
  output logic [7:0]  cpu_rdata,
  output logic [15:0] ram_addr,
  output logic        ram_we,
  output logic [7:0]  ram_wdata,
  input  logic [7:0]  ram_rdata,
  output logic        buf_we,
  output logic [1:0]  buf_sel,
  output logic        buf_row,
  output logic [7:0]  buf_idx,
  output logic [7:0]  buf_data,
  output logic        rowbuf,
  output logic        overrun
);

  typedef enum logic [2:0] {StIdle, StRefr, StScrn, StAttr, StChar} state_e;

  typedef struct packed {
    state_e     st;
    logic [7:0] idx;
  } pos_t;

  localparam logic [7:0] SMax = (S_LATCH_WIDTH > 255) ? 8'd255 : 8'(S_LATCH_WIDTH);
  localparam logic [7:0] CMax = (C_LATCH_WIDTH > 255) ? 8'd255 : 8'(C_LATCH_WIDTH);
  localparam logic [1:0] KindChar = 2'd2;
  localparam logic [1:0] KindCpu  = 2'd3;

  // Skips every exhausted phase so a zero-length phase costs no slot.
  function automatic pos_t resolve(input state_e st_in, input logic [7:0] idx_in,
                                   input logic rp, input logic [3:0] drr,
                                   input logic [7:0] ns, input logic [7:0] nc,
                                   input logic text, input logic atr);
    pos_t p;
    p.st  = st_in;
    p.idx = idx_in;
    if (p.st == StRefr && p.idx >= {4'b0000, drr}) begin
      p.st  = (rp && !text) ? StScrn : ((rp && atr) ? StAttr : StChar);
      p.idx = 8'd0;
    end
    if (p.st == StScrn && p.idx >= ns) begin
      p.st  = atr ? StAttr : StChar;
      p.idx = 8'd0;
    end
    if (p.st == StAttr && p.idx >= ns) begin
      p.st  = StChar;
      p.idx = 8'd0;
    end
    if (p.st == StChar && p.idx >= nc) begin
      p.st  = StIdle;
      p.idx = 8'd0;
    end
    return p;
  endfunction

  state_e     state_q, state_d;
  logic [7:0] idx_q, idx_d;
  logic [7:0] refcnt_q, refcnt_d;
  logic       line_pend_q, row_pend_q, rowbuf_q, overrun_q;
  logic       tag_vld_q;
  logic [1:0] tag_kind_q;
  logic [7:0] tag_idx_q;
  logic       buf_we_q, buf_row_q, cpu_ack_q;
  logic [1:0] buf_sel_q;
  logic [7:0] buf_idx_q, buf_data_q, cpu_rdata_q;

  logic [7:0]  n_s, n_c;
  logic        line_pend_eff, row_pend_eff, line_start, cpu_busy;
  pos_t        cur, eff;
  logic [15:0] addr_raw, glyph_off;
  logic        we_c, issue_tag, cpu_wack;
  logic [1:0]  issue_kind;
  logic [7:0]  wdata_c, char_idx_c;

  assign n_s           = (reg_hd > SMax) ? SMax : reg_hd;
  assign n_c           = (reg_hd > CMax) ? CMax : reg_hd;
  assign line_pend_eff = line_pend_q | fetchLine;
  assign row_pend_eff  = row_pend_q | fetchRow;
  assign line_start    = enable & line_pend_eff;
  assign cpu_busy      = tag_vld_q && (tag_kind_q == KindCpu);

  assign cur = resolve(state_q, idx_q, row_pend_eff, reg_drr, n_s, n_c, reg_text, reg_atr);
  assign eff = line_start ?
               resolve(StRefr, 8'd0, row_pend_eff, reg_drr, n_s, n_c, reg_text, reg_atr) : cur;

  assign glyph_off = reg_csz ? {3'b000, scrn_code, line} : {4'b0000, scrn_code, line[3:0]};

  always_comb begin
    addr_raw   = 16'h0000;
    we_c       = 1'b0;
    wdata_c    = 8'h00;
    issue_tag  = 1'b0;
    issue_kind = 2'd0;
    cpu_wack   = 1'b0;
    char_idx_c = 8'h00;
    refcnt_d   = refcnt_q;
    state_d    = state_q;
    idx_d      = idx_q;
    case (eff.st)
      StRefr: begin
        addr_raw = {8'h00, refcnt_q};
        if (enable) refcnt_d = refcnt_q + 8'd1;
      end
      StScrn: begin
        addr_raw   = dispaddr + {8'h00, eff.idx};
        issue_tag  = 1'b1;
        issue_kind = 2'd0;
      end
      StAttr: begin
        addr_raw   = attraddr + {8'h00, eff.idx};
        issue_tag  = 1'b1;
        issue_kind = 2'd1;
      end
      StChar: begin
        char_idx_c = eff.idx;
        addr_raw   = reg_text ? (dispaddr + {8'h00, eff.idx})
                              : ({reg_cbase, 13'b0} + glyph_off);
        issue_tag  = 1'b1;
        issue_kind = KindChar;
      end
      default: begin
        // A CPU read in flight blocks a second grant while the level request is still held.
        if (cpu_req && !cpu_busy) begin
          addr_raw   = cpu_addr;
          we_c       = cpu_we;
          wdata_c    = cpu_wdata;
          issue_tag  = !cpu_we;
          issue_kind = KindCpu;
          cpu_wack   = cpu_we;
        end
      end
    endcase
    if (enable) begin
      state_d = eff.st;
      idx_d   = (eff.st == StIdle) ? 8'd0 : eff.idx + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      idx_q       <= 8'd0;
      refcnt_q    <= 8'd0;
      line_pend_q <= 1'b0;
      row_pend_q  <= 1'b0;
      rowbuf_q    <= 1'b0;
      overrun_q   <= 1'b0;
      tag_vld_q   <= 1'b0;
      tag_kind_q  <= 2'd0;
      tag_idx_q   <= 8'd0;
      buf_we_q    <= 1'b0;
      buf_sel_q   <= 2'd0;
      buf_row_q   <= 1'b0;
      buf_idx_q   <= 8'd0;
      buf_data_q  <= 8'd0;
      cpu_ack_q   <= 1'b0;
      cpu_rdata_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      refcnt_q    <= refcnt_d;
      line_pend_q <= line_start ? 1'b0 : line_pend_eff;
      // Row fetch is done once the sequence reaches the character phase.
      row_pend_q  <= (enable && (eff.st == StChar || eff.st == StIdle)) ? 1'b0 : row_pend_eff;
      if (fetchFrame)    rowbuf_q <= 1'b0;
      else if (fetchRow) rowbuf_q <= ~rowbuf_q;
      if (line_start && cur.st != StIdle) overrun_q <= 1'b1;
      buf_we_q  <= 1'b0;
      cpu_ack_q <= 1'b0;
      if (enable) begin
        tag_vld_q  <= issue_tag;
        tag_kind_q <= issue_kind;
        tag_idx_q  <= eff.idx;
        if (tag_vld_q) begin
          if (tag_kind_q == KindCpu) begin
            cpu_ack_q   <= 1'b1;
            cpu_rdata_q <= ram_rdata;
          end else begin
            buf_we_q   <= 1'b1;
            buf_sel_q  <= tag_kind_q;
            buf_idx_q  <= tag_idx_q;
            buf_row_q  <= (tag_kind_q == KindChar) ? 1'b0 : ~rowbuf_q;
            buf_data_q <= ram_rdata;
          end
        end
        if (cpu_wack) cpu_ack_q <= 1'b1;
      end
    end
  end

  assign ram_addr  = enable ? (addr_raw & (reg_ram64 ? 16'hFFFF : 16'h3FFF)) : 16'h0000;
  assign ram_we    = enable & we_c;
  assign ram_wdata = enable ? wdata_c : 8'h00;
  assign char_idx  = char_idx_c;
  assign cpu_ack   = cpu_ack_q;
  assign cpu_rdata = cpu_rdata_q;
  assign buf_we    = buf_we_q;
  assign buf_sel   = buf_sel_q;
  assign buf_row   = buf_row_q;
  assign buf_idx   = buf_idx_q;
  assign buf_data  = buf_data_q;
  assign rowbuf    = rowbuf_q;
  assign overrun   = overrun_q;

endmodule
